multi_timer: RTL and testbench

Parametrised multi-channel programmable timer/toggle generator: NUM_CH independent channels, each with a CNT_W-bit period register and counter, producing a one-cycle tick and a toggling square wave on every period expiry. Supports free-running or one-shot mode per channel, with an optional shared prescaler. Sits beside the clock/reset generation logic as the synthesizable replacement for delay-based toggles and periodic counters, and feeds periodic strobes to the rest of the design.

---
 rtl/multi_timer_if.sv | 27 ++
 rtl/multi_timer.sv | 99 +++++++++
 tb/tb_multi_timer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_timer_if.sv
// rtl/multi_timer_if.sv - configuration and output bundle for multi_timer
interface multi_timer_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic              cfg_oneshot;
    logic [NUM_CH-1:0] ch_en;
    logic [PRE_W-1:0]  pre_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] tog_out;
    logic [NUM_CH-1:0] busy;

    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_oneshot, ch_en, pre_div,
        input  tick, tog_out, busy
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_period, cfg_oneshot, ch_en, pre_div,
        output tick, tog_out, busy
    );
endinterface

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - multi-channel period timer with tick and toggle outputs
// Optional shared prescaler compiled in with MULTI_TIMER_PRESCALE_EN.
module multi_timer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 8
) (
    input  logic           clk,
    input  logic           rst,
    multi_timer_if.slave   bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic adv;

`ifdef MULTI_TIMER_PRESCALE_EN
    logic [PRE_W-1:0] pc_q;

    // >= rather than == so lowering pre_div below pc never stalls the strobe
    assign adv = (pc_q >= bus.pre_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (adv) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_q + PRE_W'(1);
        end
    end
`else
    logic unused_pre;

    assign adv        = 1'b1;
    assign unused_pre = ^bus.pre_div;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] per_q, cnt_q, per_d, cnt_d;
        logic             mode_q, done_q, tick_q, tog_q, busy_q;
        logic             mode_d, done_d, tick_d, tog_d;
        logic             wr, live;

        // Out-of-range channel numbers never match any genvar, so they are dropped
        assign wr   = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
        assign live = bus.ch_en[i] && (per_q != '0) && !done_q && adv;

        always_comb begin
            per_d  = per_q;
            cnt_d  = cnt_q;
            mode_d = mode_q;
            done_d = done_q;
            tick_d = 1'b0;
            tog_d  = tog_q;
            if (wr) begin
                per_d  = bus.cfg_period;
                mode_d = bus.cfg_oneshot;
                cnt_d  = '0;
                done_d = 1'b0;
            end else if (!bus.ch_en[i]) begin
                cnt_d  = '0;
                done_d = 1'b0;
            end else if (live) begin
                if (cnt_q == per_q - CNT_W'(1)) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    tog_d  = ~tog_q;
                    done_d = mode_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                per_q  <= '0;
                cnt_q  <= '0;
                mode_q <= 1'b0;
                done_q <= 1'b0;
                tick_q <= 1'b0;
                tog_q  <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                per_q  <= per_d;
                cnt_q  <= cnt_d;
                mode_q <= mode_d;
                done_q <= done_d;
                tick_q <= tick_d;
                tog_q  <= tog_d;
                busy_q <= bus.ch_en[i] && (per_d != '0) && !done_d;
            end
        end

        assign bus.tick[i]    = tick_q;
        assign bus.tog_out[i] = tog_q;
        assign bus.busy[i]    = busy_q;
    end
endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - randomized and directed bench for multi_timer
module tb_multi_timer;
    localparam int NCH = 5;
    localparam int CW  = 16;
    localparam int PW  = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multi_timer_if #(.NUM_CH(NCH), .CNT_W(CW), .PRE_W(PW)) bus ();

    multi_timer #(.NUM_CH(NCH), .CNT_W(CW), .PRE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned    m_p    [NCH];
    int unsigned    m_left [NCH];
    bit             m_mode [NCH];
    bit             m_fin  [NCH];
    logic [NCH-1:0] m_tick, m_tog, m_busy;
    int unsigned    m_pc;
    int             checks = 0;
    int             errors = 0;

    // Reference: each channel counts down the adv events left before its next tick.
    task automatic step();
        bit adv;
        @(posedge clk);
`ifdef MULTI_TIMER_PRESCALE_EN
        adv = (m_pc >= int'(bus.pre_div));
`else
        adv = 1'b1;
`endif
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_p[i] = 0; m_left[i] = 0; m_mode[i] = 0; m_fin[i] = 0;
            end
            m_tick = '0; m_tog = '0; m_busy = '0; m_pc = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                m_tick[i] = 1'b0;
                if (bus.cfg_we && int'(bus.cfg_ch) == i) begin
                    m_p[i] = bus.cfg_period; m_mode[i] = bus.cfg_oneshot;
                    m_left[i] = m_p[i]; m_fin[i] = 0;
                end else if (!bus.ch_en[i]) begin
                    m_left[i] = m_p[i]; m_fin[i] = 0;
                end else if (m_p[i] != 0 && !m_fin[i] && adv) begin
                    if (m_left[i] == 1) begin
                        m_tick[i] = 1'b1; m_tog[i] = ~m_tog[i];
                        m_left[i] = m_p[i];
                        if (m_mode[i]) m_fin[i] = 1;
                    end else begin
                        m_left[i] = m_left[i] - 1;
                    end
                end
                m_busy[i] = bus.ch_en[i] && m_p[i] != 0 && !m_fin[i];
            end
            m_pc = adv ? 0 : m_pc + 1;
        end
        @(negedge clk);
    endtask

    task automatic cfg(input int ch, input int per, input bit os);
        bus.cfg_we = 1'b1; bus.cfg_ch = 3'(ch);
        bus.cfg_period = CW'(per); bus.cfg_oneshot = os;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg(0, 3, 0); bus.ch_en = '1; bus.pre_div = '0;
        repeat (3) begin
            step();
            checks++;
            if ({bus.tick, bus.tog_out, bus.busy} !== '0) begin
                errors++;
                $display("FAIL reset_out got %b required 0", {bus.tick, bus.tog_out, bus.busy});
            end
        end
        rst = 1'b0; bus.cfg_we = 1'b0;
        repeat (10) begin
            step();
            checks++;
            if ({bus.tick, bus.tog_out, bus.busy} !== {m_tick, m_tog, m_busy}) begin
                errors++;
                $display("FAIL reset_model got %b required %b", {bus.tick, bus.tog_out, bus.busy}, {m_tick, m_tog, m_busy});
            end
            checks++;
            if (bus.tick !== '0 || bus.busy !== '0) begin
                errors++;
                $display("FAIL reset_retained tick %b busy %b required 0", bus.tick, bus.busy);
            end
        end
    endtask

    task automatic test_freerun();
        int ticks = 0, flips = 0;
        logic prev;
        bus.ch_en = NCH'(1); cfg(0, 4, 0);
        step();
        bus.cfg_we = 1'b0; prev = bus.tog_out[0];
        repeat (40) begin
            step();
            checks++;
            if ({bus.tick, bus.tog_out, bus.busy} !== {m_tick, m_tog, m_busy}) begin
                errors++;
                $display("FAIL freerun_model got %b required %b", {bus.tick, bus.tog_out, bus.busy}, {m_tick, m_tog, m_busy});
            end
            checks++;
            if (bus.busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL freerun_busy got %b required 1", bus.busy[0]);
            end
            if (bus.tick[0] === 1'b1) ticks++;
            if (bus.tog_out[0] !== prev) flips++;
            prev = bus.tog_out[0];
        end
        checks++;
        if (ticks != 10 || flips != 10) begin
            errors++;
            $display("FAIL freerun_count ticks %0d flips %0d required 10 10", ticks, flips);
        end
    endtask

    task automatic test_multi();
        int n1 = 0, n2 = 0, n3 = 0, at3 = -1;
        bus.ch_en = '1;
        cfg(1, 1, 0);     step();
        cfg(2, 0, 0);     step();
        cfg(3, 65535, 0); step();
        bus.cfg_we = 1'b0;
        for (int k = 1; k <= 65540; k++) begin
            step();
            checks++;
            if ({bus.tick, bus.tog_out, bus.busy} !== {m_tick, m_tog, m_busy}) begin
                errors++;
                $display("FAIL multi_model k=%0d got %b required %b", k, {bus.tick, bus.tog_out, bus.busy}, {m_tick, m_tog, m_busy});
            end
            checks++;
            if (bus.busy[2] !== 1'b0) begin
                errors++;
                $display("FAIL multi_p0_busy k=%0d got %b required 0", k, bus.busy[2]);
            end
            if (bus.tick[1] === 1'b1) n1++;
            if (bus.tick[2] === 1'b1) n2++;
            if (bus.tick[3] === 1'b1) begin n3++; at3 = k; end
        end
        checks++;
        if (n1 != 65540 || n2 != 0 || n3 != 1 || at3 != 65535) begin
            errors++;
            $display("FAIL multi_count got %0d %0d %0d at %0d required 65540 0 1 at 65535", n1, n2, n3, at3);
        end
    endtask

    task automatic test_oneshot();
        bus.ch_en = '0; cfg(0, 3, 1);
        step();
        bus.cfg_we = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            int n = 0, at = -1;
            bus.ch_en = NCH'(1);
            for (int k = 1; k <= 23; k++) begin
                step();
                checks++;
                if ({bus.tick, bus.tog_out, bus.busy} !== {m_tick, m_tog, m_busy}) begin
                    errors++;
                    $display("FAIL oneshot_model k=%0d got %b required %b", k, {bus.tick, bus.tog_out, bus.busy}, {m_tick, m_tog, m_busy});
                end
                checks++;
                if (bus.busy[0] !== (k < 3)) begin
                    errors++;
                    $display("FAIL oneshot_busy k=%0d got %b required %b", k, bus.busy[0], k < 3);
                end
                if (bus.tick[0] === 1'b1) begin n++; at = k; end
            end
            checks++;
            if (n != 1 || at != 3) begin
                errors++;
                $display("FAIL oneshot_tick pass %0d got %0d at %0d required 1 at 3", pass, n, at);
            end
            bus.ch_en = '0;
            step();
        end
    endtask

    task automatic test_collision();
        int n = 0;
        logic tog_before;
        bus.ch_en = NCH'(1); cfg(0, 5, 0);
        step();
        bus.cfg_we = 1'b0;
        repeat (4) step();
        tog_before = bus.tog_out[0];
        cfg(0, 2, 0);
        step();
        bus.cfg_we = 1'b0;
        checks++;
        if (bus.tick[0] !== 1'b0 || bus.tog_out[0] !== tog_before) begin
            errors++;
            $display("FAIL collision_edge tick %b tog %b required 0 %b", bus.tick[0], bus.tog_out[0], tog_before);
        end
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++;
            if (bus.tick[0] !== (k == 2)) begin
                errors++;
                $display("FAIL collision_next k=%0d got %b required %b", k, bus.tick[0], k == 2);
            end
        end
        bus.ch_en = '1; cfg(NCH, 1, 1);
        step();
        bus.cfg_we = 1'b0;
        repeat (10) begin
            step();
            checks++;
            if ({bus.tick, bus.tog_out, bus.busy} !== {m_tick, m_tog, m_busy}) begin
                errors++;
                $display("FAIL badch_model got %b required %b", {bus.tick, bus.tog_out, bus.busy}, {m_tick, m_tog, m_busy});
            end
            if (bus.tick[0] === 1'b1) n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL badch_ticks got %0d required 5", n);
        end
    endtask

    task automatic test_prescale();
        int last = -1, n = 0, guard = 0;
`ifdef MULTI_TIMER_PRESCALE_EN
        int gap = 6;
`else
        int gap = 2;
`endif
        bus.ch_en = NCH'(1); bus.pre_div = PW'(2); cfg(0, 2, 0);
        step();
        bus.cfg_we = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            checks++;
            if ({bus.tick, bus.tog_out, bus.busy} !== {m_tick, m_tog, m_busy}) begin
                errors++;
                $display("FAIL prescale_model k=%0d got %b required %b", k, {bus.tick, bus.tog_out, bus.busy}, {m_tick, m_tog, m_busy});
            end
            if (bus.tick[0] === 1'b1) begin
                n++;
                checks++;
                if (last >= 0 && k - last != gap) begin
                    errors++;
                    $display("FAIL prescale_gap got %0d required %0d", k - last, gap);
                end
                last = k;
            end
        end
        checks++;
        if (n < 3) begin
            errors++;
            $display("FAIL prescale_ticks got %0d required at least 3", n);
        end
        bus.pre_div = PW'(5);
        while (m_pc != 4 && guard < 12) begin
            step();
            guard++;
        end
`ifdef MULTI_TIMER_PRESCALE_EN
        checks++;
        if (m_pc != 4) begin
            errors++;
            $display("FAIL prescale_phase got pc %0d required 4", m_pc);
        end
`endif
        bus.pre_div = PW'(1);
        repeat (12) begin
            step();
            checks++;
            if ({bus.tick, bus.tog_out, bus.busy} !== {m_tick, m_tog, m_busy}) begin
                errors++;
                $display("FAIL prescale_lower got %b required %b", {bus.tick, bus.tog_out, bus.busy}, {m_tick, m_tog, m_busy});
            end
        end
        bus.pre_div = '0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.cfg_we = ($urandom_range(0, 3) == 0);
            bus.cfg_ch = 3'($urandom_range(0, 7));
            bus.cfg_period = CW'($urandom_range(0, 5));
            bus.cfg_oneshot = 1'($urandom());
            bus.ch_en = bus.ch_en ^ NCH'($urandom() & $urandom() & $urandom());
            if ($urandom_range(0, 15) == 0) bus.pre_div = PW'($urandom_range(0, 3));
            step();
            checks++;
            if ({bus.tick, bus.tog_out, bus.busy} !== {m_tick, m_tog, m_busy}) begin
                errors++;
                $display("FAIL random k=%0d got %b required %b", k, {bus.tick, bus.tog_out, bus.busy}, {m_tick, m_tog, m_busy});
            end
        end
        rst = 1'b0; bus.cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_period = '0;
        bus.cfg_oneshot = 1'b0; bus.ch_en = '0; bus.pre_div = '0;
        m_pc = 0;
        test_reset();
        test_freerun();
        test_multi();
        test_oneshot();
        test_collision();
        test_prescale();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
